// File: rtl/mem_port_responder.sv
// Unified CPU memory-port responder: one request per handshake, WAIT_STATES wait cycles, big-endian byte array.
// Define MEM_PORT_ALIGN_CHECK_EN to flag misaligned accesses; otherwise low address bits are forced to zero.
module mem_port_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              accept_c, enter_resp_c;

    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              write_q;
    logic [31:0]       wdata_q;

    logic [ADDR_W-1:0] cur_addr, base_c, a0, a1, a2, a3;
    logic [1:0]        cur_size;
    logic              cur_write;
    logic [31:0]       cur_wdata;
    logic              misalign_c, err_c;
    logic [31:0]       rdata_c;

    logic [7:0]        mem [DEPTH];

    assign req_ready = reset_n && (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign rsp_valid = (state == ST_RESP);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    accept_c = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_nxt = ST_RESP;
                    end else begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = CNT_W'(WAIT_STATES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == '0) state_nxt = ST_RESP;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign enter_resp_c = reset_n && (state != ST_RESP) && (state_nxt == ST_RESP);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q  <= '0;
            size_q  <= 2'b00;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else if (accept_c) begin
            addr_q  <= req_addr[ADDR_W-1:0];
            size_q  <= req_size;
            write_q <= req_write;
            wdata_q <= req_wdata;
        end
    end

    // With zero wait states the access happens on the accepting edge, so bypass the latch in IDLE.
    assign cur_addr  = (state == ST_IDLE) ? req_addr[ADDR_W-1:0] : addr_q;
    assign cur_size  = (state == ST_IDLE) ? req_size  : size_q;
    assign cur_write = (state == ST_IDLE) ? req_write : write_q;
    assign cur_wdata = (state == ST_IDLE) ? req_wdata : wdata_q;

    always_comb begin
        base_c     = cur_addr;
        misalign_c = 1'b0;
        case (cur_size)
            2'b00: base_c = cur_addr;
            2'b01: begin
                misalign_c = cur_addr[0];
                base_c[0]  = 1'b0;
            end
            default: begin
                misalign_c  = |cur_addr[1:0];
                base_c[1:0] = 2'b00;
            end
        endcase
    end

`ifdef MEM_PORT_ALIGN_CHECK_EN
    assign err_c = misalign_c;
    logic unused_c;
    assign unused_c = ^req_addr[31:ADDR_W];
`else
    assign err_c = 1'b0;
    logic unused_c;
    assign unused_c = ^{req_addr[31:ADDR_W], misalign_c};
`endif

    assign a0 = base_c;
    assign a1 = base_c + ADDR_W'(1);
    assign a2 = base_c + ADDR_W'(2);
    assign a3 = base_c + ADDR_W'(3);

    // Big-endian: lowest address lands in the most significant byte of the returned field.
    always_comb begin
        case (cur_size)
            2'b00:   rdata_c = {24'h0, mem[a0]};
            2'b01:   rdata_c = {16'h0, mem[a0], mem[a1]};
            default: rdata_c = {mem[a0], mem[a1], mem[a2], mem[a3]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (enter_resp_c && cur_write && !err_c) begin
            case (cur_size)
                2'b00: mem[a0] <= cur_wdata[7:0];
                2'b01: begin
                    mem[a0] <= cur_wdata[15:8];
                    mem[a1] <= cur_wdata[7:0];
                end
                default: begin
                    mem[a0] <= cur_wdata[31:24];
                    mem[a1] <= cur_wdata[23:16];
                    mem[a2] <= cur_wdata[15:8];
                    mem[a3] <= cur_wdata[7:0];
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (enter_resp_c) begin
            rsp_err   <= err_c;
            rsp_rdata <= (cur_write || err_c) ? '0 : rdata_c;
        end else begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_port_responder.sv
// Scoreboard bench for mem_port_responder: driver pushes model-derived expectations, negedge monitor pops and compares.
module tb_mem_port_responder;
    localparam int unsigned AW    = 8;
    localparam int unsigned WS    = 3;
    localparam int unsigned BYTES = 1 << AW;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t       q[$];
    logic [7:0] ref_mem [BYTES];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         tmo = 0;
    bit         done = 1'b0;
    bit         final_done = 1'b0;
    bit         prev_rst_n = 1'b1;

    mem_port_responder #(.ADDR_W(AW), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: byte-array access of 1/2/4 bytes, most significant byte at the lowest address.
    function automatic void model(input bit w, input logic [1:0] sz, input logic [31:0] addr,
                                  input logic [31:0] d, output logic [31:0] rd, output logic e);
        int n, a;
        n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        a  = int'(addr % BYTES);
        rd = 32'h0;
        e  = 1'b0;
`ifdef MEM_PORT_ALIGN_CHECK_EN
        if (a % n != 0) begin
            e = 1'b1;
            return;
        end
`endif
        a = a - (a % n);
        for (int i = 0; i < n; i++) begin
            if (w) ref_mem[a + i] = 8'(d >> (8 * (n - 1 - i)));
            else   rd = (rd << 8) | 32'(ref_mem[a + i]);
        end
        if (w) rd = 32'h0;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input bit w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d, input bit abandon);
        int          n;
        exp_t        e;
        logic [31:0] rd;
        logic        er;
        step();
        req_valid = 1'b1;
        req_write = w;
        req_size  = sz;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        while (!req_ready && n < 60) begin
            step();
            n++;
        end
        if (!req_ready) begin
            tmo++;
            req_valid = 1'b0;
            return;
        end
        if (!abandon) begin
            model(w, sz, a, d, rd, er);
            e.rdata = rd;
            e.err   = er;
            e.cyc   = cyc + 1 + int'(WS);
            q.push_back(e);
        end
        step();
        req_valid = 1'b0;
        req_write = 1'($urandom_range(0, 1));
        req_size  = 2'($urandom_range(0, 3));
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            if (!prev_rst_n) begin
                chk(req_ready === 1'b0, "rst_ready", 32'(req_ready), 32'd0);
                chk(rsp_valid === 1'b0, "rst_valid", 32'(rsp_valid), 32'd0);
                chk(busy === 1'b0, "rst_busy", 32'(busy), 32'd0);
            end
        end else begin
            if (!prev_rst_n) begin
                chk(req_ready === 1'b1, "post_rst_ready", 32'(req_ready), 32'd1);
                chk(rsp_rdata === 32'h0, "post_rst_rdata", rsp_rdata, 32'h0);
            end
            if (rsp_valid === 1'b1) begin
                chk(q.size() != 0, "unexpected_rsp", rsp_rdata, 32'h0);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk(rsp_rdata === e.rdata, "rdata", rsp_rdata, e.rdata);
                    chk(rsp_err === e.err, "err", 32'(rsp_err), 32'(e.err));
                    chk(cyc == e.cyc, "latency_cycle", 32'(cyc), 32'(e.cyc));
                    chk(busy === 1'b1 && req_ready === 1'b0, "resp_busy_ready",
                        32'({busy, req_ready}), 32'b10);
                end
            end else begin
                chk(rsp_rdata === 32'h0 && rsp_err === 1'b0, "idle_zero", rsp_rdata, 32'h0);
            end
        end
        prev_rst_n = reset_n;
        if (done && !final_done) begin
            chk(q.size() == 0, "drain", 32'(q.size()), 32'd0);
            chk(tmo == 0, "ready_timeout", 32'(tmo), 32'd0);
            final_done = 1'b1;
        end
    end

    initial begin
        int          n;
        int          gap;
        logic [31:0] a;
        repeat (3) step();
        reset_n = 1'b1;

        // Preload the whole array through the port so the model knows every byte.
        for (int i = 0; i < int'(BYTES / 4); i++) issue(1'b1, 2'b10, 32'(4 * i), $urandom, 1'b0);

        issue(1'b1, 2'b10, 32'h0000_0000, 32'h1234_5678, 1'b0);
        issue(1'b1, 2'b00, 32'h0000_0004, 32'h0000_0011, 1'b0);
        issue(1'b0, 2'b10, 32'h0000_0000, 32'h0, 1'b0);
        issue(1'b1, 2'b00, 32'h0000_0005, 32'h0000_00AB, 1'b0);
        issue(1'b0, 2'b01, 32'h0000_0004, 32'h0, 1'b0);
        issue(1'b1, 2'b10, 32'h0000_0008, 32'hDEAD_BEEF, 1'b0);
        issue(1'b0, 2'b00, 32'h0000_000B, 32'h0, 1'b0);
        issue(1'b0, 2'b10, 32'h0000_0002, 32'h0, 1'b0);
        issue(1'b1, 2'b10, 32'h0000_0002, 32'hCAFE_F00D, 1'b0);
        issue(1'b0, 2'b10, 32'h0000_0000, 32'h0, 1'b0);
        issue(1'b0, 2'b01, 32'h0000_0003, 32'h0, 1'b0);
        issue(1'b0, 2'b11, 32'h0000_0004, 32'h0, 1'b0);
        issue(1'b1, 2'b00, 32'h0000_00FD, 32'h0000_007C, 1'b0);
        issue(1'b0, 2'b00, 32'hFFFF_FFFD, 32'h0, 1'b0);
        issue(1'b0, 2'b10, 32'h0000_0100, 32'h0, 1'b0);
        issue(1'b0, 2'b10, 32'h0000_00FC, 32'h0, 1'b0);

        // Store abandoned by reset during the second wait cycle must leave the byte untouched.
        issue(1'b1, 2'b00, 32'h0000_0010, 32'h0000_005A, 1'b0);
        issue(1'b1, 2'b00, 32'h0000_0010, 32'h0000_00FF, 1'b1);
        step();
        reset_n = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        issue(1'b0, 2'b00, 32'h0000_0010, 32'h0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) step();
            if ($urandom_range(0, 3) == 0) a = $urandom;
            else                           a = 32'($urandom_range(0, 31));
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom, 1'b0);
        end

        n = 0;
        while (q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        done = 1'b1;
        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
